matrix_result_tx_formatter: RTL and testbench
=============================================

Name: matrix_result_tx_formatter

Overview:
Downstream consumer of the matrix core's result port. On a start pulse it snapshots the result matrix (up to 5x5 signed 16-bit elements) and serialises it as ASCII decimal text, byte by byte, into the UART transmitter. Rows are space-separated and CR/LF-terminated. It owns the byte-level handshake with the UART TX block and reports completion or a dimension error back to the control FSM.

Parameters:
MAX_DIM, 5, maximum rows/columns accepted
ELEM_W, 16, element width in bits, two's complement
SEP_CHAR, 8'h20, ASCII separator between elements of one row

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  level; its rising edge (detected internally) requests a print
mat_m  input  4  result rows
mat_n  input  4  result columns
mat_flat  input  MAX_DIM*MAX_DIM*ELEM_W (400)  row-major; element (i,j) at [(i*MAX_DIM+j)*ELEM_W +: ELEM_W]
tx_busy  input  1  UART TX busy; rises the cycle after an accepted tx_start
tx_data  output  8  ASCII byte to send
tx_start  output  1  one-cycle send strobe
busy  output  1  high from accepted start until done/err
done  output  1  one-cycle pulse after the last LF is accepted
err  output  1  one-cycle pulse on invalid dimensions

Behaviour:
- Reset is asynchronous, active-low, on rst_n. Clock is clk.
- Reset values: tx_data=8'h00, tx_start=0, busy=0, done=0, err=0; FSM=IDLE; start edge register=0.
- IDLE: on a start rising edge, check dimensions. If mat_m or mat_n is 0 or >MAX_DIM: pulse err the next cycle, send no bytes, stay IDLE. Otherwise latch mat_m, mat_n and mat_flat, set busy, reset row/col indices to 0 and go to CONV.
- Start edges while busy are ignored. Input changes after latching have no effect.
- CONV: take the element at (row,col).
  - If negative, set the sign flag and take magnitude = -value in 17 bits (-32768 gives 32768).
  - Convert by sequential double-dabble: 1 load cycle plus 16 shift/add-3 cycles = 17 cycles, producing 5 BCD digits.
  - Leading zeros suppressed; value 0 emits a single '0'.
- Emission order per element: '-' if negative, then significant digits MSD first as 8'h30+digit.
- After an element:
  - col < n-1: emit SEP_CHAR, col+1, back to CONV.
  - Otherwise: emit 8'h0D then 8'h0A, col=0, row+1.
  - If the row was the last: DONE instead of CONV.
- No trailing separator is sent before CR.
- Byte handshake, per byte:
  - SEND: drive tx_data and pulse tx_start for 1 cycle, only when tx_busy=0.
  - GAP: one dead cycle.
  - WAIT: hold until tx_busy=0.
  - Then move to the next byte. tx_data is held stable from SEND through WAIT.
- If tx_busy is held high indefinitely, the block stalls in WAIT. There is no timeout and no byte is dropped or duplicated.
- DONE: pulse done for 1 cycle, clear busy, return to IDLE.
- Reset mid-operation aborts immediately to reset values. A partially sent matrix is not resumed.

Optional Feature:
MATRIX_TX_HEADER_EN:
- Defined: before the body, emit the header ASCII(m), 'x', ASCII(n), CR, LF, e.g. "2x3\r\n". The header uses the same handshake; done is unaffected except for the extra bytes.
- Undefined: no header; the first byte is the first byte of element (0,0).

Test Plan:
- 1x1, element 16'h0000, tx_busy model 3 cycles per byte -> bytes 30 0D 0A, then one done pulse; busy low afterwards.
- 2x2 [1,-2;30,400] -> exact stream "1 -2\r\n30 400\r\n" (14 bytes); tx_start never asserted while tx_busy=1.
- 1x2 [-32768, 32767] -> "-32768 32767\r\n"; mat_flat changed mid-print -> output unchanged.
- mat_m=0, mat_n=3, and separately mat_m=6, mat_n=1 -> err pulse, zero tx_start, busy stays 0.
- Start re-pulsed while busy, and tx_busy forced high for 1000 cycles mid-stream -> no extra print, stall then correct resume, single done.
- rst_n low during the 3rd byte of the 2x2 case -> all outputs at reset values immediately; a following start yields the full correct stream.

Source files
------------

// File: rtl/matrix_result_tx_formatter.sv
// Snapshots a result matrix on a start edge and streams it to the UART as ASCII decimal rows: 17-cycle double-dabble per element, one byte per tx_busy handshake.
// tx_busy high stalls the stream indefinitely with nothing dropped; defining MATRIX_TX_HEADER_EN prefixes the body with an "MxN\r\n" header.
module matrix_result_tx_formatter #(
  parameter int         MAX_DIM  = 5,
  parameter int         ELEM_W   = 16,
  parameter logic [7:0] SEP_CHAR = 8'h20
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [3:0]                        mat_m,
  input  logic [3:0]                        mat_n,
  input  logic [MAX_DIM*MAX_DIM*ELEM_W-1:0] mat_flat,
  input  logic                              tx_busy,
  output logic [7:0]                        tx_data,
  output logic                              tx_start,
  output logic                              busy,
  output logic                              done,
  output logic                              err
);

  localparam int NEL   = MAX_DIM * MAX_DIM;
  localparam int IDX_W = $clog2(NEL);
  localparam int CNT_W = $clog2(ELEM_W + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_SHIFT, ST_PICK, ST_SEND, ST_GAP, ST_WAIT, ST_DONE
  } state_t;

  typedef enum logic [3:0] {
    SP_SIGN, SP_LEAD, SP_DIG, SP_SEP, SP_CR, SP_LF, SP_NXTE, SP_NXTR,
    SP_HM, SP_HX, SP_HN, SP_HCR, SP_HLF, SP_HEND
  } step_t;

  state_t             state_q, state_d;
  step_t              step_q, step_d;
  logic               start_q, start_d;
  logic [3:0]         m_q, m_d, n_q, n_d, row_q, row_d, col_q, col_d;
  logic               neg_q, neg_d;
  logic [ELEM_W-1:0]  bin_q, bin_d;
  logic [19:0]        bcd_q, bcd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         dig_q, dig_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;
  logic               busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic [ELEM_W-1:0]  elem_q [NEL];
  logic               latch_en;
  logic [IDX_W-1:0]   idx;
  logic [ELEM_W-1:0]  elem, mag;
  logic [19:0]        bcd_adj, bcd_sh;
  logic [3:0]         dg, cur_dig;
  logic               bad_dim;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NEL; k++) elem_q[k] <= '0;
    end else if (latch_en) begin
      for (int k = 0; k < NEL; k++) elem_q[k] <= mat_flat[k*ELEM_W +: ELEM_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      step_q     <= SP_LEAD;
      start_q    <= 1'b0;
      m_q        <= '0;
      n_q        <= '0;
      row_q      <= '0;
      col_q      <= '0;
      neg_q      <= 1'b0;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      dig_q      <= '0;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      start_q    <= start_d;
      m_q        <= m_d;
      n_q        <= n_d;
      row_q      <= row_d;
      col_q      <= col_d;
      neg_q      <= neg_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      dig_q      <= dig_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    start_d    = start;
    m_d        = m_q;
    n_d        = n_q;
    row_d      = row_q;
    col_d      = col_q;
    neg_d      = neg_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    dig_d      = dig_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    latch_en   = 1'b0;

    idx  = IDX_W'(row_q) * IDX_W'(MAX_DIM) + IDX_W'(col_q);
    elem = elem_q[idx];
    // Unsigned magnitude: the most negative value maps onto its own bit pattern.
    mag  = elem[ELEM_W-1] ? (~elem + ELEM_W'(1)) : elem;

    dg      = 4'd0;
    bcd_adj = bcd_q;
    for (int k = 0; k < 5; k++) begin
      dg = bcd_q[k*4 +: 4];
      bcd_adj[k*4 +: 4] = (dg >= 4'd5) ? dg + 4'd3 : dg;
    end
    bcd_sh  = bcd_q >> {dig_q, 2'b00};
    cur_dig = bcd_sh[3:0];
    bad_dim = (mat_m == 4'd0) || (mat_m > 4'(MAX_DIM)) ||
              (mat_n == 4'd0) || (mat_n > 4'(MAX_DIM));

    case (state_q)
      ST_IDLE: begin
        if (start && !start_q) begin
          if (bad_dim) begin
            err_d = 1'b1;
          end else begin
            latch_en = 1'b1;
            m_d      = mat_m;
            n_d      = mat_n;
            row_d    = '0;
            col_d    = '0;
            busy_d   = 1'b1;
`ifdef MATRIX_TX_HEADER_EN
            state_d  = ST_PICK;
            step_d   = SP_HM;
`else
            state_d  = ST_LOAD;
`endif
          end
        end
      end
      ST_LOAD: begin
        neg_d   = elem[ELEM_W-1];
        bin_d   = mag;
        bcd_d   = '0;
        cnt_d   = '0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ELEM_W - 1)) begin
          state_d = ST_PICK;
          dig_d   = 3'd4;
          step_d  = neg_q ? SP_SIGN : SP_LEAD;
        end
      end
      ST_PICK: begin
        case (step_q)
          SP_SIGN: begin
            tx_data_d = 8'h2D;
            step_d    = SP_LEAD;
            state_d   = ST_SEND;
          end
          // Walk down past leading zeros; digit 0 is always printed.
          SP_LEAD: begin
            if (dig_q != 3'd0 && cur_dig == 4'd0) dig_d = dig_q - 3'd1;
            else                                  step_d = SP_DIG;
          end
          SP_DIG: begin
            tx_data_d = 8'h30 + {4'h0, cur_dig};
            state_d   = ST_SEND;
            if (dig_q == 3'd0) step_d = (col_q == n_q - 4'd1) ? SP_CR : SP_SEP;
            else               dig_d  = dig_q - 3'd1;
          end
          SP_SEP: begin
            tx_data_d = SEP_CHAR;
            step_d    = SP_NXTE;
            state_d   = ST_SEND;
          end
          SP_CR: begin
            tx_data_d = 8'h0D;
            step_d    = SP_LF;
            state_d   = ST_SEND;
          end
          SP_LF: begin
            tx_data_d = 8'h0A;
            step_d    = SP_NXTR;
            state_d   = ST_SEND;
          end
          SP_NXTE: begin
            col_d   = col_q + 4'd1;
            state_d = ST_LOAD;
          end
          SP_NXTR: begin
            col_d = '0;
            if (row_q == m_q - 4'd1) begin
              state_d = ST_DONE;
            end else begin
              row_d   = row_q + 4'd1;
              state_d = ST_LOAD;
            end
          end
`ifdef MATRIX_TX_HEADER_EN
          SP_HM: begin
            tx_data_d = 8'h30 + {4'h0, m_q};
            step_d    = SP_HX;
            state_d   = ST_SEND;
          end
          SP_HX: begin
            tx_data_d = 8'h78;
            step_d    = SP_HN;
            state_d   = ST_SEND;
          end
          SP_HN: begin
            tx_data_d = 8'h30 + {4'h0, n_q};
            step_d    = SP_HCR;
            state_d   = ST_SEND;
          end
          SP_HCR: begin
            tx_data_d = 8'h0D;
            step_d    = SP_HLF;
            state_d   = ST_SEND;
          end
          SP_HLF: begin
            tx_data_d = 8'h0A;
            step_d    = SP_HEND;
            state_d   = ST_SEND;
          end
          SP_HEND: state_d = ST_LOAD;
`endif
          default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
        endcase
      end
      ST_SEND: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          state_d    = ST_GAP;
        end
      end
      // tx_start is visible during GAP; the UART's busy is settled by WAIT.
      ST_GAP:  state_d = ST_WAIT;
      ST_WAIT: if (!tx_busy) state_d = ST_PICK;
      ST_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_matrix_result_tx_formatter.sv
// Randomised bench for matrix_result_tx_formatter: a UART busy model captures the byte stream and it is compared with text formatted from the matrix values.
module tb_matrix_result_tx_formatter;
  localparam int MAX_DIM = 5;
  localparam int ELEM_W  = 16;
  localparam int NEL     = MAX_DIM * MAX_DIM;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    start;
  logic [3:0]              mat_m, mat_n;
  logic [NEL*ELEM_W-1:0]   mat_flat;
  logic                    tx_busy;
  logic [7:0]              tx_data;
  logic                    tx_start, busy, done, err;

  matrix_result_tx_formatter dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mat_m(mat_m), .mat_n(mat_n),
    .mat_flat(mat_flat), .tx_busy(tx_busy), .tx_data(tx_data),
    .tx_start(tx_start), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  logic signed [15:0] el [NEL];
  byte unsigned rx [$];
  int busy_len = 3;
  bit stall = 1'b0;
  int done_cnt = 0, err_cnt = 0, start_cnt = 0, viol = 0;
  bit busy_seen = 1'b0;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // UART side: busy rises the cycle after an accepted strobe and stays up busy_len cycles.
  initial begin
    int  cnt;
    bit  pend;
    cnt = 0;
    pend = 1'b0;
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cnt = 0;
        pend = 1'b0;
        tx_busy = 1'b0;
      end else begin
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (busy) busy_seen = 1'b1;
        if (pend) begin
          cnt = busy_len;
          pend = 1'b0;
        end
        if (tx_start) begin
          start_cnt++;
          if (tx_busy) viol++;
          rx.push_back(tx_data);
          pend = 1'b1;
        end
        tx_busy = (cnt > 0) || stall;
        if (cnt > 0) cnt--;
      end
    end
  end

  function automatic string model_text(input int m, input int n);
    string s;
    int v;
    s = "";
`ifdef MATRIX_TX_HEADER_EN
    s = $sformatf("%0dx%0d%c%c", m, n, 8'h0d, 8'h0a);
`endif
    for (int i = 0; i < m; i++) begin
      for (int j = 0; j < n; j++) begin
        v = el[i*MAX_DIM + j];
        s = {s, $sformatf("%0d", v)};
        if (j < n - 1) s = {s, $sformatf("%c", 8'h20)};
      end
      s = {s, $sformatf("%c%c", 8'h0d, 8'h0a)};
    end
    return s;
  endfunction

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #2;
  endtask

  task automatic pack();
    for (int k = 0; k < NEL; k++) mat_flat[k*ELEM_W +: ELEM_W] = el[k];
  endtask

  task automatic clear_mon();
    rx.delete();
    done_cnt = 0;
    err_cnt = 0;
    start_cnt = 0;
    viol = 0;
    busy_seen = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(2);
    start = 1'b0;
    tick(1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int c;
    c = 0;
    while (done_cnt == 0 && c < budget) begin
      tick(1);
      c++;
    end
    if (done_cnt == 0) chk({tag, "_done_timeout"}, 0, 1);
    tick(3);
  endtask

  task automatic wait_bytes(input string tag, input int k, input int budget);
    int c;
    c = 0;
    while (rx.size() < k && c < budget) begin
      tick(1);
      c++;
    end
    if (rx.size() < k) chk({tag, "_byte_timeout"}, rx.size(), k);
  endtask

  task automatic check_stream(input string tag, input string s);
    int lim;
    chk({tag, "_len"}, rx.size(), s.len());
    lim = (rx.size() < s.len()) ? rx.size() : s.len();
    for (int i = 0; i < lim; i++)
      chk($sformatf("%s_byte%0d", tag, i), int'(rx[i]), int'(s[i]));
  endtask

  task automatic run_case(input string tag, input int m, input int n);
    mat_m = 4'(m);
    mat_n = 4'(n);
    pack();
    clear_mon();
    pulse_start();
    wait_done(tag, 20000);
    check_stream(tag, model_text(m, n));
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_busy_viol"}, viol, 0);
    chk({tag, "_busy_after"}, int'(busy), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tx_data"}, int'(tx_data), 0);
    chk({tag, "_tx_start"}, int'(tx_start), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_err"}, int'(err), 0);
  endtask

  function automatic logic signed [15:0] rand_elem();
    case ($urandom_range(0, 5))
      0: return 16'sd0;
      1: return -16'sd32768;
      2: return 16'sd32767;
      3: return 16'($signed($urandom_range(0, 20)) - 10);
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int snap;
    rst_n = 1'b0;
    start = 1'b0;
    mat_m = '0;
    mat_n = '0;
    mat_flat = '0;
    for (int k = 0; k < NEL; k++) el[k] = '0;
    tick(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick(2);

    busy_len = 3;
    run_case("zero1x1", 1, 1);

    for (int k = 0; k < NEL; k++) el[k] = '0;
    el[0] = 16'sd1; el[1] = -16'sd2; el[5] = 16'sd30; el[6] = 16'sd400;
    busy_len = int'($urandom_range(1, 4));
    run_case("m2x2", 2, 2);

    // Inputs scrambled after the snapshot must not leak into the stream.
    el[0] = -16'sd32768; el[1] = 16'sd32767;
    mat_m = 4'd1; mat_n = 4'd2;
    pack();
    clear_mon();
    pulse_start();
    tick(30);
    for (int k = 0; k < NEL; k++) mat_flat[k*ELEM_W +: ELEM_W] = 16'($urandom);
    mat_m = 4'd4; mat_n = 4'd5;
    wait_done("extremes", 20000);
    check_stream("extremes", model_text(1, 2));
    chk("extremes_done_cnt", done_cnt, 1);

    mat_m = 4'd0; mat_n = 4'd3;
    clear_mon();
    pulse_start();
    tick(5);
    chk("err_m0_pulse", err_cnt, 1);
    chk("err_m0_bytes", start_cnt, 0);
    chk("err_m0_busy", int'(busy_seen), 0);
    mat_m = 4'd6; mat_n = 4'd1;
    clear_mon();
    pulse_start();
    tick(5);
    chk("err_m6_pulse", err_cnt, 1);
    chk("err_m6_bytes", start_cnt, 0);
    chk("err_m6_busy", int'(busy_seen), 0);

    for (int k = 0; k < NEL; k++) el[k] = rand_elem();
    busy_len = 2;
    mat_m = 4'd3; mat_n = 4'd3;
    pack();
    clear_mon();
    pulse_start();
    wait_bytes("stall", 4, 5000);
    stall = 1'b1;
    tick(5);
    snap = rx.size();
    pulse_start();
    tick(990);
    chk("stall_no_bytes", rx.size(), snap);
    chk("stall_busy", int'(busy), 1);
    stall = 1'b0;
    pulse_start();
    wait_done("stall", 20000);
    check_stream("stall", model_text(3, 3));
    tick(50);
    chk("stall_single_done", done_cnt, 1);
    chk("stall_no_reprint", start_cnt, model_text(3, 3).len());
    chk("stall_busy_viol", viol, 0);

    for (int k = 0; k < NEL; k++) el[k] = '0;
    el[0] = 16'sd1; el[1] = -16'sd2; el[5] = 16'sd30; el[6] = 16'sd400;
    busy_len = 3;
    mat_m = 4'd2; mat_n = 4'd2;
    pack();
    clear_mon();
    pulse_start();
    wait_bytes("midreset", 3, 5000);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    tick(2);
    rst_n = 1'b1;
    tick(2);
    run_case("after_reset", 2, 2);

    for (int it = 0; it < 8; it++) begin
      int m, n;
      m = int'($urandom_range(1, MAX_DIM));
      n = int'($urandom_range(1, MAX_DIM));
      for (int k = 0; k < NEL; k++) el[k] = rand_elem();
      busy_len = int'($urandom_range(1, 5));
      run_case($sformatf("rand%0d", it), m, n);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
